fifo_tx_serializer: RTL and testbench

Transmit-side serializer that drains the read port of the async FIFO and shifts each word out on a single-bit line. Each word is framed as a start bit, data bits LSB first, an optional parity bit and a stop bit. Sits directly downstream of the FIFO read port, in the read clock domain, and drives the SERDES transmit line.

---
 rtl/fifo_tx_serializer.sv | 165 ++++++++++++++++
 tb/tb_fifo_tx_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_tx_serializer
//  Purpose  : Drains the read port of the async FIFO and shifts each word out
//             on a single-bit line, framed as a start bit, data LSB first, an
//             optional even-parity bit and a stop bit. Each line bit is held
//             for CLKS_PER_BIT clocks.
//  Ports    : i_clk        - read-domain clock, rising edge
//             i_rst        - asynchronous active-high reset
//             i_en         - transmit enable, sampled only while idle
//             i_rempty     - FIFO empty flag
//             o_rr         - FIFO read request (combinational, idle only)
//             i_rdata      - FIFO read data, valid the cycle after a pop
//             o_tx         - registered serial line, idles high
//             o_busy       - high whenever a frame is in progress
//             o_frame_done - one-cycle pulse on the last cycle of the stop bit
//  Options  : define FIFO_TX_SERIALIZER_PARITY_EN to insert an even-parity bit
//             between the data bits and the stop bit.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_tx_serializer #(
  parameter int LOGIC_SIZE   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_rempty,
  output logic                  o_rr,
  input  logic [LOGIC_SIZE-1:0] i_rdata,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (LOGIC_SIZE > 1) ? $clog2(LOGIC_SIZE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(LOGIC_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BAUD_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [LOGIC_SIZE-1:0]   shift_reg;
  logic                    baud_tc;
  logic                    tx_next;
  logic                    frame_end;

  assign baud_tc   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_tc;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_rr       = 1'b0;
    case (state)
      IDLE: begin
        // Reset gates the request so no word is popped while held in reset.
        o_rr = i_en && !i_rempty && !i_rst;
        if (o_rr) state_next = LOAD;
      end
      LOAD:  state_next = START;
      START: if (baud_tc) state_next = DATA;
      DATA: begin
        if (baud_tc && (bit_cnt == BIT_LAST)) begin
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      PARITY: if (baud_tc) state_next = STOP;
`endif
      STOP:  if (baud_tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Baud/bit counters and the data shift register. The baud counter runs
  // in every on-line state and wraps at terminal count, which marks the
  // bit boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
        end
        LOAD: begin
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          shift_reg <= i_rdata;
        end
        default: begin
          baud_cnt <= baud_tc ? '0 : baud_cnt + 1'b1;
          if ((state == DATA) && baud_tc) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FIFO_TX_SERIALIZER_PARITY_EN
  logic parity_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      parity_bit <= 1'b0;
    end else if (state == LOAD) begin
      parity_bit <= ^i_rdata;
    end
  end
`endif

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START: tx_next = 1'b0;
      DATA:  tx_next = shift_reg[0];
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      PARITY: tx_next = parity_bit;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // The line and the done pulse are registered, so both lag the state by
  // one cycle and stay aligned with each other.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tx         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      o_tx         <= tx_next;
      o_frame_done <= frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_tx_serializer
//  Purpose  : Self-checking bench for fifo_tx_serializer. A queue stands in
//             for the FIFO; each expected frame is built from the word with
//             the framing rules (start, LSB-first data, optional parity,
//             stop) and compared cycle by cycle on the line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_tx_serializer;

  localparam int LS  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, rempty, rr, tx, busy, fd;
  logic [LS-1:0] rdata;
  logic          en1, rempty1, rr1, tx1, busy1, fd1;
  logic [LS-1:0] rdata1;

  int            compared = 0;
  int            mismatched = 0;
  int            pops = 0;
  int            p0;
  logic [LS-1:0] q[$];
  logic [LS-1:0] sent_q[$];

  always #5 clk = ~clk;

  fifo_tx_serializer #(.LOGIC_SIZE(LS), .CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_rempty(rempty), .o_rr(rr),
    .i_rdata(rdata), .o_tx(tx), .o_busy(busy), .o_frame_done(fd)
  );

  fifo_tx_serializer #(.LOGIC_SIZE(LS), .CLKS_PER_BIT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_rempty(rempty1), .o_rr(rr1),
    .i_rdata(rdata1), .o_tx(tx1), .o_busy(busy1), .o_frame_done(fd1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: the read request seen just before the edge pops the FIFO
  // model, whose data is then presented for the following cycle.
  task automatic tick();
    logic rr_s;
    @(negedge clk);
    rr_s = rr;
    @(posedge clk);
    #1;
    if (rr_s) begin
      if (q.size() > 0) rdata = q.pop_front();
      pops++;
    end
    rempty = (q.size() == 0);
  endtask

  task automatic push(input logic [LS-1:0] w);
    q.push_back(w);
    sent_q.push_back(w);
    rempty = 1'b0;
  endtask

  // Line bits of one frame, LSB first in the returned vector.
  function automatic int build_frame(input logic [LS-1:0] w, output logic [15:0] fb);
    int idx;
    fb = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < LS; i++) fb[i+1] = w[i];
    idx = LS + 1;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    fb[idx] = ^w;
    idx++;
`endif
    fb[idx] = 1'b1;
    return idx + 1;
  endfunction

  task automatic gap();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("gap_high", tx, 1);
    end
  endtask

  // Waits at most max_wait clocks for the start bit, then checks every
  // line cycle of the next expected frame. drop_at clears i_en at that
  // frame cycle; abort_at returns just before checking that frame cycle.
  task automatic expect_frame(input int max_wait, input int drop_at, input int abort_at);
    logic [LS-1:0] w;
    logic [15:0]   fb;
    int            nb, found, cyc;
    w = (sent_q.size() > 0) ? sent_q.pop_front() : '0;
    nb = build_frame(w, fb);
    found = 0;
    for (int i = 0; i < max_wait && found == 0; i++) begin
      tick();
      if (tx === 1'b0) found = 1;
    end
    check("frame_start", found, 1);
    if (found == 0) return;
    cyc = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (cyc != 0) tick();
        if (cyc == abort_at) return;
        check("tx_bit", tx, fb[b]);
        check("frame_done", fd, (b == nb - 1 && c == CPB - 1) ? 1 : 0);
        if (cyc == drop_at) en = 1'b0;
        cyc++;
      end
    end
  endtask

  initial begin
    logic [15:0] fb1;
    int          nb1, nrand;

    rst = 1'b1; en = 1'b0; rempty = 1'b1; rdata = '0;
    en1 = 1'b0; rempty1 = 1'b1; rdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_rr", rr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", fd, 0);
    check("rst_tx1", tx1, 1);
    check("rst_busy1", busy1, 0);
    rst = 1'b0;

    // Empty FIFO with transmit enabled: nothing happens.
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty_rr", rr, 0);
      check("empty_tx", tx, 1);
      check("empty_busy", busy, 0);
    end

    // Non-empty but disabled: no pop.
    en = 1'b0;
    push(8'hA5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("dis_rr", rr, 0);
      check("dis_busy", busy, 0);
    end
    check("dis_pops", pops, 0);

    // Single word with exact pop-to-start latency.
    en = 1'b1;
    #1;
    check("pop_req", rr, 1);
    tick();
    check("load_busy", busy, 1);
    check("load_rr", rr, 0);
    check("load_tx", tx, 1);
    tick();
    check("start_lat_tx", tx, 1);
    expect_frame(1, -1, -1);
    check("single_pops", pops, 1);
    tick();
    check("post_busy", busy, 0);
    check("post_rr", rr, 0);

    // Back-to-back frames, including all-zero, all-one and parity-one words.
    push(8'h00);
    push(8'hFF);
    push(8'h01);
    expect_frame(4, -1, -1);
    gap();
    expect_frame(1, -1, -1);
    gap();
    expect_frame(1, -1, -1);
    check("b2b_pops", pops, 4);

    // Random words streamed back to back.
    p0 = pops;
    nrand = 4 + int'($urandom_range(0, 3));
    for (int i = 0; i < nrand; i++) push(LS'($urandom_range(0, 255)));
    expect_frame(4, -1, -1);
    for (int i = 1; i < nrand; i++) begin
      gap();
      expect_frame(1, -1, -1);
    end
    check("rand_pops", pops, p0 + nrand);

    // Enable dropped mid-frame: frame completes, no further pop.
    p0 = pops;
    push(LS'($urandom_range(0, 255)));
    push(LS'($urandom_range(0, 255)));
    expect_frame(4, 10, -1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("drop_rr", rr, 0);
      check("drop_busy", busy, 0);
      check("drop_tx", tx, 1);
    end
    check("drop_pops", pops, p0 + 1);

    // Reset during data bit 3: line high and idle at once, word lost.
    p0 = pops;
    en = 1'b1;
    expect_frame(4, -1, 4 * CPB + 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    check("arst_done", fd, 0);
    push(LS'($urandom_range(0, 255)));
    #1;
    check("arst_rr", rr, 0);
    tick();
    tick();
    check("arst_pops", pops, p0 + 1);
    rst = 1'b0;
    expect_frame(4, -1, -1);
    check("post_rst_pops", pops, p0 + 2);

    // One clock per bit on the second instance.
    en1 = 1'b1;
    rempty1 = 1'b0;
    #1;
    check("cpb1_rr", rr1, 1);
    @(posedge clk);
    #1;
    rempty1 = 1'b1;
    rdata1 = 8'h3C;
    check("cpb1_load_busy", busy1, 1);
    check("cpb1_load_rr", rr1, 0);
    @(posedge clk);
    #1;
    check("cpb1_lat_tx", tx1, 1);
    nb1 = build_frame(8'h3C, fb1);
    for (int b = 0; b < nb1; b++) begin
      @(posedge clk);
      #1;
      check("cpb1_tx", tx1, fb1[b]);
      check("cpb1_done", fd1, (b == nb1 - 1) ? 1 : 0);
    end
    en1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
